// File: rtl/ram_simple_dp_synch_param.sv
`default_nettype none
// ============================================================================
//  Module   : ram_simple_dp_synch_param
//  Purpose  : Parametrised simple dual-port synchronous RAM. One write port
//             with per-byte lane enables and one read port share a single
//             clock. The read-during-write behaviour can be selected, and an
//             output register can be added.
//  Ports    : clk        - single clock, rising edge
//             rst        - synchronous active-high reset (pipeline only)
//             we, be     - write enable and byte-lane enables
//             write_addr - write word address
//             din        - write data
//             re         - read enable
//             read_addr  - read word address
//             dout       - read data (holds when no read completes)
//             dout_valid - one-cycle strobe that marks a completed read
//  Revision : 1.0 - initial release
// ============================================================================
module ram_simple_dp_synch_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter int BYTE_WIDTH = 8,
    parameter int RDW_MODE   = 0,   // 0: read-first, 1: write-first
    parameter int OUT_REG    = 0    // 1: extra output register stage
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic [ADDR_WIDTH-1:0]            write_addr,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic                             re,
    input  logic [ADDR_WIDTH-1:0]            read_addr,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             dout_valid
);

    localparam int c_NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH can equal 2**ADDR_WIDTH, so the range compare uses one extra bit.
    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_wr_en;
    logic                  w_collide;
    logic [c_IDX_W-1:0]    w_waddr_idx;
    logic [c_IDX_W-1:0]    w_raddr_idx;
    logic [DATA_WIDTH-1:0] w_lane_mask;
    logic [DATA_WIDTH-1:0] w_old_word;
    logic [DATA_WIDTH-1:0] w_merged_word;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    // The full address is range-checked before the index is narrowed. An
    // out-of-range access therefore never lands on a legal word.
    assign w_wr_in_range = {1'b0, write_addr} < c_DEPTH;
    assign w_rd_in_range = {1'b0, read_addr}  < c_DEPTH;
    assign w_waddr_idx   = write_addr[c_IDX_W-1:0];
    assign w_raddr_idx   = read_addr[c_IDX_W-1:0];
    assign w_wr_en       = we && !rst && w_wr_in_range;
    assign w_collide     = w_wr_en && (read_addr == write_addr);

    for (genvar k = 0; k < c_NB; k++) begin : g_lane_mask
        assign w_lane_mask[k*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{be[k]}};
    end

    assign w_old_word    = r_mem[w_raddr_idx];
    // This is the word the read address will hold after this edge's write.
    assign w_merged_word = (din & w_lane_mask) | (w_old_word & ~w_lane_mask);

    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            if ((RDW_MODE != 0) && w_collide) begin
                w_rd_word = w_merged_word;
            end else begin
                w_rd_word = w_old_word;
            end
        end
    end

    // The array is intentionally never reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < c_NB; k++) begin
                if (be[k]) begin
                    r_mem[w_waddr_idx][k*BYTE_WIDTH +: BYTE_WIDTH] <=
                        din[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // First read stage: the data holds between reads and the valid flag
    // pulses once for each accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= re;
            if (re) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] r_out_data;
        logic                  r_out_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_out_data  <= '0;
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_rd_valid;
                if (r_rd_valid) begin
                    r_out_data <= r_rd_data;
                end
            end
        end

        assign dout       = r_out_data;
        assign dout_valid = r_out_valid;
    end else begin : g_no_out_reg
        assign dout       = r_rd_data;
        assign dout_valid = r_rd_valid;
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_simple_dp_synch_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_simple_dp_synch_param
//  Purpose  : Self-checking bench for ram_simple_dp_synch_param. Two
//             instances share one stimulus stream:
//               A: read-first, latency 1
//               B: write-first, latency 2
//             Both instances use DEPTH=1000 and ADDR_WIDTH=10.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_simple_dp_synch_param;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1000;
    localparam int NB    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we  = 1'b0;
    logic [NB-1:0] be  = '0;
    logic [AW-1:0] write_addr = '0;
    logic [DW-1:0] din = '0;
    logic          re  = 1'b0;
    logic [AW-1:0] read_addr = '0;

    logic [DW-1:0] dout_a, dout_b;
    logic          va, vb;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: the word array, plus the value each output should show.
    logic [DW-1:0] model [0:1023];
    logic [DW-1:0] ea_d, eb_d, pend_d;
    bit            ea_v, eb_v, pend_v;

    always #5 clk = ~clk;

    ram_simple_dp_synch_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .BYTE_WIDTH(8),
        .RDW_MODE(0), .OUT_REG(0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .we(we), .be(be), .write_addr(write_addr),
        .din(din), .re(re), .read_addr(read_addr),
        .dout(dout_a), .dout_valid(va)
    );

    ram_simple_dp_synch_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .BYTE_WIDTH(8),
        .RDW_MODE(1), .OUT_REG(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .we(we), .be(be), .write_addr(write_addr),
        .din(din), .re(re), .read_addr(read_addr),
        .dout(dout_b), .dout_valid(vb)
    );

    task automatic drive(input bit r, input bit w, input logic [AW-1:0] wa,
                         input logic [DW-1:0] d, input logic [NB-1:0] b,
                         input bit rd, input logic [AW-1:0] ra);
        rst = r; we = w; write_addr = wa; din = d; be = b; re = rd; read_addr = ra;
    endtask

    // Apply one clock edge and update the reference model. Outputs are
    // settled when this task returns.
    task automatic step();
        logic [DW-1:0] old_w, merged, res_a, res_b;
        bit            go;
        go     = re && !rst;
        old_w  = model[read_addr];
        merged = model[write_addr];
        for (int k = 0; k < NB; k++)
            if (be[k]) merged[k*8 +: 8] = din[k*8 +: 8];
        if (read_addr >= DEPTH) begin
            res_a = '0; res_b = '0;
        end else if (we && write_addr == read_addr) begin
            res_a = old_w; res_b = merged;
        end else begin
            res_a = old_w; res_b = old_w;
        end
        if (rst) begin
            ea_d = '0; ea_v = 0; eb_d = '0; eb_v = 0; pend_d = '0; pend_v = 0;
        end else begin
            eb_v = pend_v;
            if (pend_v) eb_d = pend_d;
            pend_v = go;
            if (go) pend_d = res_b;
            ea_v = go;
            if (go) ea_d = res_a;
            if (we && write_addr < DEPTH) model[write_addr] = merged;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 10'd3, 32'hDEADBEEF, 4'hF, 1, 10'd3);
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (dout_a !== 32'h0 || va !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_a: dout=%h valid=%b, want 00000000/0", dout_a, va);
            end
            n_cmp++;
            if (dout_b !== 32'h0 || vb !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_b: dout=%h valid=%b, want 00000000/0", dout_b, vb);
            end
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, AW'(i), $urandom, 4'hF, 0, '0);
            step();
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(0, 0, '0, '0, '0, (i < DEPTH), AW'(i % DEPTH));
            step();
            n_cmp++;
            if (dout_a !== ea_d || va !== ea_v) begin
                n_fail++;
                $display("FAIL sweep_a i=%0d: dout=%h valid=%b, want %h/%b", i, dout_a, va, ea_d, ea_v);
            end
            n_cmp++;
            if (dout_b !== eb_d || vb !== eb_v) begin
                n_fail++;
                $display("FAIL sweep_b i=%0d: dout=%h valid=%b, want %h/%b", i, dout_b, vb, eb_d, eb_v);
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] wa, ra;
        for (int i = 0; i < 500; i++) begin
            wa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 1023)) : AW'($urandom_range(0, 7));
            ra = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 1023)) : AW'($urandom_range(0, 7));
            drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1), wa, $urandom,
                  NB'($urandom), $urandom_range(0, 2) != 0, ra);
            step();
            n_cmp++;
            if (dout_a !== ea_d || va !== ea_v) begin
                n_fail++;
                $display("FAIL random_a i=%0d: dout=%h valid=%b, want %h/%b", i, dout_a, va, ea_d, ea_v);
            end
            n_cmp++;
            if (dout_b !== eb_d || vb !== eb_v) begin
                n_fail++;
                $display("FAIL random_b i=%0d: dout=%h valid=%b, want %h/%b", i, dout_b, vb, eb_d, eb_v);
            end
        end
        drive(0, 0, '0, '0, '0, 0, '0);
        step();
        step();
    endtask

    task automatic test_byte_en();
        drive(0, 1, 10'd5, 32'hFFFFFFFF, 4'hF, 0, '0);
        step();
        drive(0, 1, 10'd5, 32'h12345678, 4'b0101, 0, '0);
        step();
        drive(0, 0, '0, '0, '0, 1, 10'd5);
        step();
        n_cmp++;
        if (dout_a !== 32'hFF34FF78 || va !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_en_a: dout=%h valid=%b, want ff34ff78/1", dout_a, va);
        end
        drive(0, 0, '0, '0, '0, 0, '0);
        step();
        n_cmp++;
        if (dout_b !== 32'hFF34FF78 || vb !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_en_b: dout=%h valid=%b, want ff34ff78/1", dout_b, vb);
        end
    endtask

    task automatic test_collision();
        drive(0, 1, 10'd7, 32'hAAAAAAAA, 4'hF, 0, '0);
        step();
        drive(0, 1, 10'd7, 32'h55555555, 4'hF, 1, 10'd7);
        step();
        n_cmp++;
        if (dout_a !== 32'hAAAAAAAA || va !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_a: dout=%h valid=%b, want aaaaaaaa/1", dout_a, va);
        end
        drive(0, 0, '0, '0, '0, 1, 10'd7);
        step();
        n_cmp++;
        if (dout_b !== 32'h55555555 || vb !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_b: dout=%h valid=%b, want 55555555/1", dout_b, vb);
        end
        n_cmp++;
        if (dout_a !== 32'h55555555 || va !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_follow_a: dout=%h valid=%b, want 55555555/1", dout_a, va);
        end
        drive(0, 0, '0, '0, '0, 0, '0);
        step();
        n_cmp++;
        if (dout_b !== 32'h55555555 || vb !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_follow_b: dout=%h valid=%b, want 55555555/1", dout_b, vb);
        end
    endtask

    task automatic test_reset_burst();
        // Each entry holds: read enable, reset, read address.
        bit            t_re [8] = '{1, 1, 1, 1, 0, 0, 1, 0};
        bit            t_rs [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
        logic [AW-1:0] t_ra [8] = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd0, 10'd0, 10'd2, 10'd0};
        for (int i = 0; i < 8; i++) begin
            drive(t_rs[i], 0, '0, '0, '0, t_re[i], t_ra[i]);
            step();
            n_cmp++;
            if (dout_a !== ea_d || va !== ea_v) begin
                n_fail++;
                $display("FAIL rst_burst_a i=%0d: dout=%h valid=%b, want %h/%b", i, dout_a, va, ea_d, ea_v);
            end
            n_cmp++;
            if (dout_b !== eb_d || vb !== eb_v) begin
                n_fail++;
                $display("FAIL rst_burst_b i=%0d: dout=%h valid=%b, want %h/%b", i, dout_b, vb, eb_d, eb_v);
            end
        end
    endtask

    task automatic test_range();
        drive(0, 1, 10'd1010, 32'hCAFEF00D, 4'hF, 0, '0);
        step();
        drive(0, 0, '0, '0, '0, 1, 10'd1010);
        step();
        n_cmp++;
        if (dout_a !== 32'h0 || va !== 1'b1) begin
            n_fail++;
            $display("FAIL range_oob_a: dout=%h valid=%b, want 00000000/1", dout_a, va);
        end
        drive(0, 0, '0, '0, '0, 1, 10'd10);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 0) drive(0, 0, '0, '0, '0, 0, '0);
            n_cmp++;
            if (dout_a !== ea_d || va !== ea_v) begin
                n_fail++;
                $display("FAIL range_a i=%0d: dout=%h valid=%b, want %h/%b", i, dout_a, va, ea_d, ea_v);
            end
            n_cmp++;
            if (dout_b !== eb_d || vb !== eb_v) begin
                n_fail++;
                $display("FAIL range_b i=%0d: dout=%h valid=%b, want %h/%b", i, dout_b, vb, eb_d, eb_v);
            end
        end
    endtask

    task automatic test_hold();
        drive(0, 1, 10'd20, 32'h0BADF00D, 4'hF, 0, '0);
        step();
        drive(0, 0, '0, '0, '0, 1, 10'd20);
        step();
        drive(0, 0, '0, '0, '0, 0, '0);
        step();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (dout_a !== 32'h0BADF00D || va !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_a i=%0d: dout=%h valid=%b, want 0badf00d/0", i, dout_a, va);
            end
            n_cmp++;
            if (dout_b !== eb_d || vb !== eb_v) begin
                n_fail++;
                $display("FAIL hold_b i=%0d: dout=%h valid=%b, want %h/%b", i, dout_b, vb, eb_d, eb_v);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_random();
        test_byte_en();
        test_collision();
        test_reset_burst();
        test_range();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
